// File: rtl/alu_seq.sv
// Handshaked Y86-64 ALU: registered add/sub/and/xor, iterative signed multiply, ZF/SF/OF register.
// Build option: define ALU_SAT_EN to saturate add/sub/mul results on signed overflow.
module alu_seq #(
    parameter int WIDTH  = 64,
    parameter int CTRL_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CTRL_W-1:0] control,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              set_cc,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WIDTH-1:0]  ans,
    output logic              overflow,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        cc
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [CTRL_W-1:0] OP_ADD = CTRL_W'(0);
    localparam logic [CTRL_W-1:0] OP_SUB = CTRL_W'(1);
    localparam logic [CTRL_W-1:0] OP_AND = CTRL_W'(2);
    localparam logic [CTRL_W-1:0] OP_XOR = CTRL_W'(3);
    localparam logic [CTRL_W-1:0] OP_MUL = CTRL_W'(4);

`ifdef ALU_SAT_EN
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   ans_q;
    logic               ovf_q;
    logic               out_valid_q;
    logic [2:0]         cc_q;

    // Multiplier datapath: magnitudes, product sign and the latched set_cc.
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic               neg;
    logic [CNT_W-1:0]   cnt;
    logic               cc_pend;

    logic               accept;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   op_res;
    logic               op_ovf;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     prod_hi;
    logic [WIDTH-1:0]   mul_res;
    logic               mul_ovf;

    assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign ans       = ans_q;
    assign overflow  = ovf_q;
    assign out_valid = out_valid_q;
    assign cc        = cc_q;

    // |MIN| wraps to itself, which is the correct unsigned magnitude 2^(WIDTH-1).
    assign a_mag = a[WIDTH-1] ? -a : a;
    assign b_mag = b[WIDTH-1] ? -b : b;

    // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        sum    = a + b;
        diff   = a - b;
        op_res = '0;
        op_ovf = 1'b0;
        case (control)
            OP_ADD: begin
                op_res = sum;
                op_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                op_res = diff;
                op_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  op_res = a & b;
            OP_XOR:  op_res = a ^ b;
            default: op_res = '0;
        endcase
`ifdef ALU_SAT_EN
        // On add/sub overflow the true result carries the sign of a.
        if (op_ovf) op_res = a[WIDTH-1] ? MIN_NEG : MAX_POS;
`endif
    end

    // Final multiply step: last shift-add, sign application and overflow detection in one edge.
    always_comb begin
        acc_step = acc + (mplier[0] ? mcand : '0);
        prod     = neg ? -acc_step : acc_step;
        prod_hi  = prod[2*WIDTH-1:WIDTH-1];
        mul_ovf  = (|prod_hi) && !(&prod_hi);
        mul_res  = prod[WIDTH-1:0];
`ifdef ALU_SAT_EN
        if (mul_ovf) mul_res = neg ? MIN_NEG : MAX_POS;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: datapath registers are reset too; they are few and this keeps simulation free of X.
            state       <= IDLE;
            ans_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            cc_q        <= 3'b100;
            mcand       <= '0;
            mplier      <= '0;
            acc         <= '0;
            neg         <= 1'b0;
            cnt         <= '0;
            cc_pend     <= 1'b0;
        end else if (accept) begin
            cc_pend <= set_cc;
            if (control == OP_MUL) begin
                state       <= MUL;
                out_valid_q <= 1'b0;
                mcand       <= {{WIDTH{1'b0}}, a_mag};
                mplier      <= b_mag;
                acc         <= '0;
                neg         <= a[WIDTH-1] ^ b[WIDTH-1];
                cnt         <= '0;
            end else begin
                state       <= DONE;
                out_valid_q <= 1'b1;
                ans_q       <= op_res;
                ovf_q       <= op_ovf;
                if (set_cc) cc_q <= {op_res == '0, op_res[WIDTH-1], op_ovf};
            end
        end else if (state == DONE && out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
        end else if (state == MUL) begin
            if (cnt == CNT_W'(WIDTH - 1)) begin
                state       <= DONE;
                out_valid_q <= 1'b1;
                ans_q       <= mul_res;
                ovf_q       <= mul_ovf;
                if (cc_pend) cc_q <= {mul_res == '0, mul_res[WIDTH-1], mul_ovf};
            end else begin
                acc    <= acc_step;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed cases plus randomized ops under random backpressure,
// checked against a wide-arithmetic reference model (honours ALU_SAT_EN).
module tb_alu_seq;

    localparam int W  = 64;
    localparam int W2 = 2 * W;
    localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [2:0]   control = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         set_cc = 1'b0;
    logic         in_valid = 1'b0;
    wire          in_ready;
    wire  [W-1:0] ans;
    wire          overflow;
    wire          out_valid;
    wire          out_ready;
    wire  [2:0]   cc;

    logic or_dir = 1'b1;
    logic bp_en = 1'b0;
    logic rnd_ready = 1'b1;
    assign out_ready = bp_en ? rnd_ready : or_dir;

    alu_seq #(.WIDTH(W), .CTRL_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .control(control), .a(a), .b(b),
        .set_cc(set_cc), .in_valid(in_valid), .in_ready(in_ready),
        .ans(ans), .overflow(overflow), .out_valid(out_valid),
        .out_ready(out_ready), .cc(cc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1 rnd_ready = ($urandom_range(0, 3) != 0);
    end

    typedef struct packed {
        logic [W-1:0] ans;
        logic         ovf;
        logic [2:0]   cc;
    } exp_t;

    exp_t       q[$];
    exp_t       mon_e;
    int         n_vec = 0;
    int         n_bad = 0;
    logic [2:0] model_cc = 3'b100;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference: exact result in 2*W-bit signed arithmetic, overflow = result does not fit in W bits.
    function automatic exp_t model(input logic [2:0] ctl, input logic signed [W-1:0] x,
                                   input logic signed [W-1:0] y);
        logic signed [W2-1:0] t;
        logic signed [W-1:0]  r;
        exp_t e;
        case (ctl)
            3'd0:    t = W2'(x) + W2'(y);
            3'd1:    t = W2'(x) - W2'(y);
            3'd2:    t = W2'(x & y);
            3'd3:    t = W2'(x ^ y);
            3'd4:    t = W2'(x) * W2'(y);
            default: t = '0;
        endcase
        r     = t[W-1:0];
        e.ovf = (t != W2'(r));
`ifdef ALU_SAT_EN
        if (e.ovf) r = (t < 0) ? MINV : MAXV;
`endif
        e.ans = r;
        e.cc  = {r == '0, r[W-1], e.ovf};
        return e;
    endfunction

    // Monitor: pops on handshake, checks held values while stalled.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_result: got ans %h, expected no result", ans);
            end else if (out_ready) begin
                mon_e = q.pop_front();
                check("ans", ans, mon_e.ans);
                check("overflow", W'(overflow), W'(mon_e.ovf));
                check("cc", W'(cc), W'(mon_e.cc));
            end else begin
                check("stall_ans", ans, q[0].ans);
                check("stall_overflow", W'(overflow), W'(q[0].ovf));
            end
        end
    end

    // Called and returns just after a rising edge; the op is accepted on the last edge waited.
    task automatic issue(input logic [2:0] ctl, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic sc, output int waits);
        exp_t e;
        bit   ok;
        control  = ctl;
        a        = x;
        b        = y;
        set_cc   = sc;
        in_valid = 1'b1;
        waits    = 0;
        ok       = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            waits++;
        end
        if (!ok) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout: got in_ready low for 300 cycles, expected accept");
            @(posedge clk);
            #1 in_valid = 1'b0;
            return;
        end
        e = model(ctl, x, y);
        if (sc) model_cc = e.cc;
        e.cc = model_cc;
        q.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
        if (ctl != 3'd4) check("latency1_valid", W'(out_valid), W'(1'b1));
    endtask

    task automatic mul_run(input logic [W-1:0] x, input logic [W-1:0] y);
        int w;
        int k;
        bit rdy_bad;
        issue(3'd4, x, y, 1'b1, w);
        k       = 0;
        rdy_bad = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (out_valid) begin
                k = i;
                break;
            end
            if (in_ready) rdy_bad = 1'b1;
        end
        check("mul_latency", W'(k), W'(W + 1));
        check("mul_in_ready_low", W'(rdy_bad), '0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return MINV;
            3:       return MAXV;
            4:       return W'($signed($urandom_range(0, 40)) - 20);
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        int w;
        int drain;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ans", ans, '0);
        check("rst_overflow", W'(overflow), '0);
        check("rst_out_valid", W'(out_valid), '0);
        check("rst_cc", W'(cc), W'(3'b100));
        check("rst_in_ready", W'(in_ready), W'(1'b1));
        @(posedge clk);
        #1 rst_n = 1'b1;

        issue(3'd0, 64'd11, 64'd4, 1'b1, w);
        check("cc_add", W'(cc), W'(3'b000));
        issue(3'd1, -64'sd11, 64'd4, 1'b1, w);
        check("b2b_sub_wait", W'(w), '0);
        check("cc_sub", W'(cc), W'(3'b010));
        issue(3'd3, 64'd11, 64'd11, 1'b1, w);
        check("b2b_xor_wait", W'(w), '0);
        check("cc_xor", W'(cc), W'(3'b100));
        issue(3'd0, MAXV, 64'd1, 1'b1, w);
`ifdef ALU_SAT_EN
        check("cc_add_ovf", W'(cc), W'(3'b001));
`else
        check("cc_add_ovf", W'(cc), W'(3'b011));
`endif

        mul_run(64'd3, -64'sd5);
        mul_run(64'h4000_0000_0000_0000, 64'd4);
        mul_run(MINV, -64'sd1);
        mul_run('0, -64'sd7);

        // Backpressure: result held while a set_cc=0 op waits behind it.
        or_dir = 1'b0;
        issue(3'd0, 64'd5, 64'd6, 1'b1, w);
        control  = 3'd2;
        a        = 64'hF0F0;
        b        = 64'h0FF0;
        set_cc   = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", W'(out_valid), W'(1'b1));
            check("bp_in_ready", W'(in_ready), '0);
            check("bp_cc", W'(cc), W'(model_cc));
        end
        @(posedge clk);
        #1;
        q.push_back({model(3'd2, 64'hF0F0, 64'h0FF0).ans, 1'b0, model_cc});
        or_dir = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("bp_second_valid", W'(out_valid), W'(1'b1));
        check("bp_second_cc", W'(cc), W'(3'b000));

        // Reset in the middle of a multiply.
        issue(3'd4, 64'd12345, 64'd678, 1'b1, w);
        repeat (19) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        q.delete();
        model_cc = 3'b100;
        check("midrst_out_valid", W'(out_valid), '0);
        check("midrst_in_ready", W'(in_ready), W'(1'b1));
        check("midrst_cc", W'(cc), W'(3'b100));
        check("midrst_ans", ans, '0);
        issue(3'd0, 64'd1, 64'd1, 1'b0, w);

        // Random ops under random backpressure.
        bp_en = 1'b1;
        for (int n = 0; n < 150; n++) begin
            issue(3'($urandom_range(0, 7)), pick(), pick(), 1'($urandom_range(0, 1)), w);
        end
        drain = 0;
        while (q.size() != 0 && drain < 500) begin
            @(posedge clk);
            drain++;
        end
        check("drain", W'(q.size()), '0);
        bp_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish within 100000 cycles");
        $fatal(1);
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the combinational Y86-64 ALU.
- Registers its result and adds an iterative signed multiply mode.
- Holds a condition-code register (ZF/SF/OF) that the execute stage reads for cmov/jXX decisions.
- Sits between decode and memory stages of the sequential core; a single op is in flight at a time.

Parameters:
WIDTH, 64, operand/result width in bits (min 8)
CTRL_W, 3, width of control field

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
control  input  CTRL_W  op select: 000 add, 001 sub, 010 and, 011 xor, 100 mul, 101-111 reserved
a  input  WIDTH  signed operand A
b  input  WIDTH  signed operand B
set_cc  input  1  update CC register when this op completes
in_valid  input  1  request valid
in_ready  output  1  block can accept request this cycle
ans  output  WIDTH  signed result, held stable while out_valid
overflow  output  1  signed overflow of this result
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
cc  output  3  {ZF,SF,OF}, registered

Behaviour:
- Reset (rst_n=0 at edge):
  - state=IDLE; ans=0; overflow=0; out_valid=0; cc=3'b100 (ZF=1).
  - Any in-flight op is discarded and does not touch cc.
- States: IDLE, MUL, DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- Accept: in_valid && in_ready at an edge; a, b, control and set_cc are latched.
- Single-cycle ops (add/sub/and/xor/reserved):
  - Next state DONE; ans/overflow registered at the accept edge.
  - out_valid=1 from the following cycle (latency 1).
  - Back-to-back accepts give throughput 1 when out_ready=1.
- add: ans = a+b mod 2^WIDTH; overflow = (a[msb]==b[msb]) && (ans[msb]!=a[msb]).
- sub: ans = a-b mod 2^WIDTH; overflow = (a[msb]!=b[msb]) && (ans[msb]!=a[msb]).
- and/xor: bitwise; overflow=0.
- Reserved codes: ans=0, overflow=0; cc is updated normally if set_cc.
- mul:
  - Accept moves state to MUL and loads |a|, |b| and the product sign.
  - Unsigned shift-add, one bit per cycle, WIDTH cycles, 2*WIDTH-bit accumulator.
  - After the last iteration, apply the sign, then go to DONE.
  - ans = low WIDTH bits of the signed product.
  - overflow=1 iff the 2*WIDTH product is not the sign-extension of ans.
  - out_valid asserts exactly WIDTH+1 cycles after the accept edge.
  - in_ready=0 throughout MUL.
  - Special cases: a=0 or b=0 gives ans=0, overflow=0. a=MIN with b=-1 gives ans=MIN, overflow=1.
- DONE:
  - ans/overflow/out_valid held until out_valid && out_ready.
  - On handshake: new accept in the same cycle goes to its next state; otherwise IDLE with out_valid=0.
  - ans retains its last value after the handshake.
- CC update:
  - Occurs on the edge where a result enters DONE, only if its latched set_cc=1.
  - ZF = (ans==0); SF = ans[msb]; OF = overflow.
  - Otherwise cc holds.
- Simultaneous events:
  - Reset dominates all.
  - in_valid while busy in MUL is ignored (not latched); the requester must hold in_valid.

Optional Feature:
ALU_SAT_EN:
- Defined: add/sub with overflow=1 clamp ans to max positive (0111..1) if the true result is positive, else min negative (100..0).
- mul overflow clamps by the sign of the true product.
- overflow and OF are still reported as 1; ZF/SF are computed from the clamped ans.
- Undefined: wrap-around results as specified above.

Test Plan:
- WIDTH=64, add a=11 b=4 set_cc=1 -> next cycle out_valid=1, ans=15, overflow=0, cc=000 after the DONE edge.
- sub a=-11 b=4 -> ans=-15, SF=1. Then xor a=11 b=11 -> ans=0, ZF=1. Back-to-back with out_ready=1 gives one result per cycle.
- add a=64'h7FFFFFFFFFFFFFFF b=1 -> ans=64'h8000000000000000, overflow=1, cc=011. With ALU_SAT_EN: ans=64'h7FFFFFFFFFFFFFFF, cc=001.
- mul a=3 b=-5 -> in_ready=0 for 64 cycles, out_valid on cycle 65, ans=-15, overflow=0. Second case: mul a=2^62 b=4 -> overflow=1.
- Backpressure: out_ready=0 for 5 cycles after an add result -> ans/out_valid stable, in_ready=0, cc unchanged by a held set_cc=0 op.
- Reset: rst_n=0 at MUL cycle 20 -> next cycle out_valid=0, in_ready=1, cc=100. A following add 1+1 returns 2.
